// File: rtl/rom_load_sequencer.sv
// Loads one ROM slot from SD card sectors into cartridge RAM, holding the console
// CPU in reset until the whole slot has been written.
module rom_load_sequencer #(
  parameter logic [31:0] BASE_SECTOR    = 32'd0,
  parameter int          SECTOR_SHIFT   = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000,
  parameter logic [7:0]  RELEASE_CYCLES = 8'd16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      do_load_rom,
  input  logic [15:0]               selected_rom,
  input  logic                      sd_initialized,
  output logic                      sd_rd_req,
  output logic [31:0]               sd_rd_sector,
  input  logic                      sd_rd_ack,
  input  logic                      sd_byte_valid,
  input  logic [7:0]                sd_byte,
  output logic                      ram_we,
  output logic [SECTOR_SHIFT+8:0]   ram_addr,
  output logic [7:0]                ram_data,
  output logic                      cpu_reset,
  output logic                      loading,
  output logic                      load_done,
  output logic                      load_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SD, S_REQ, S_DATA, S_RELEASE, S_ERROR
  } state_t;

  state_t                    state_q;
  logic [15:0]               slot_q;
  logic                      pending_q;
  logic [31:0]               base_q;
  logic [SECTOR_SHIFT-1:0]   sec_q;
  logic [8:0]                byte_q;
  logic [23:0]               to_q;
  logic [7:0]                rel_q;
  logic                      sd_rd_req_q;
  logic [31:0]               sd_rd_sector_q;
  logic                      ram_we_q;
  logic [SECTOR_SHIFT+8:0]   ram_addr_q;
  logic [7:0]                ram_data_q;
  logic                      cpu_reset_q;
  logic                      loading_q;
  logic                      load_done_q;
  logic                      load_error_q;

  logic [31:0]               slot_base_d;
  logic [SECTOR_SHIFT-1:0]   sec_inc_d;
  logic [31:0]               next_sector_d;
  logic                      timeout_hit_d;

  // The running load keeps its own base so a newer request cannot disturb it.
  assign slot_base_d   = BASE_SECTOR + ({16'd0, slot_q} << SECTOR_SHIFT);
  assign sec_inc_d     = sec_q + SECTOR_SHIFT'(1);
  assign next_sector_d = base_q + 32'(sec_inc_d);
  assign timeout_hit_d = (to_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      slot_q         <= '0;
      pending_q      <= 1'b0;
      base_q         <= '0;
      sec_q          <= '0;
      byte_q         <= '0;
      to_q           <= '0;
      rel_q          <= '0;
      sd_rd_req_q    <= 1'b0;
      sd_rd_sector_q <= '0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_data_q     <= '0;
      cpu_reset_q    <= 1'b1;
      loading_q      <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      ram_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (pending_q) begin
            pending_q    <= 1'b0;
            base_q       <= slot_base_d;
            load_error_q <= 1'b0;
            loading_q    <= 1'b1;
            cpu_reset_q  <= 1'b1;
            state_q      <= S_WAIT_SD;
          end
        end
        S_WAIT_SD: begin
          if (sd_initialized) begin
            sec_q          <= '0;
            byte_q         <= '0;
            to_q           <= '0;
            sd_rd_req_q    <= 1'b1;
            sd_rd_sector_q <= base_q;
            state_q        <= S_REQ;
          end
        end
        S_REQ: begin
          if (sd_rd_ack) begin
            sd_rd_req_q <= 1'b0;
            to_q        <= '0;
            state_q     <= S_DATA;
          end else if (timeout_hit_d) begin
            sd_rd_req_q  <= 1'b0;
            load_error_q <= 1'b1;
            loading_q    <= 1'b0;
            state_q      <= S_ERROR;
          end else begin
            to_q <= to_q + 24'd1;
          end
        end
        S_DATA: begin
          if (sd_byte_valid) begin
            ram_we_q   <= 1'b1;
            ram_data_q <= sd_byte;
            ram_addr_q <= {sec_q, byte_q};
            byte_q     <= byte_q + 9'd1;
            to_q       <= '0;
            if (&byte_q) begin
              if (&sec_q) begin
                rel_q   <= '0;
                state_q <= S_RELEASE;
              end else begin
                sec_q          <= sec_inc_d;
                sd_rd_req_q    <= 1'b1;
                sd_rd_sector_q <= next_sector_d;
                state_q        <= S_REQ;
              end
            end
          end else if (timeout_hit_d) begin
            load_error_q <= 1'b1;
            loading_q    <= 1'b0;
            state_q      <= S_ERROR;
          end else begin
            to_q <= to_q + 24'd1;
          end
        end
        S_RELEASE: begin
          if (rel_q == RELEASE_CYCLES - 8'd1) begin
            cpu_reset_q <= 1'b0;
            loading_q   <= 1'b0;
            load_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            rel_q <= rel_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Placed last so a pulse coinciding with a load start is kept as the next request.
      if (do_load_rom) begin
        pending_q <= 1'b1;
        slot_q    <= selected_rom;
      end
    end
  end

  assign sd_rd_req    = sd_rd_req_q;
  assign sd_rd_sector = sd_rd_sector_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign loading      = loading_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomized bench for rom_load_sequencer: an SD reader emulation feeds bytes while a
// transaction-level model predicts sector addresses, RAM writes and completion timing.
module tb_rom_load_sequencer;

  localparam logic [31:0] BASE  = 32'd100;
  localparam int          SHIFT = 1;
  localparam logic [23:0] TMO   = 24'd100;
  localparam logic [7:0]  REL   = 8'd16;
  localparam int          NSEC  = 1 << SHIFT;

  logic              clk;
  logic              reset_n;
  logic              do_load_rom;
  logic [15:0]       selected_rom;
  logic              sd_initialized;
  logic              sd_rd_req;
  logic [31:0]       sd_rd_sector;
  logic              sd_rd_ack;
  logic              sd_byte_valid;
  logic [7:0]        sd_byte;
  logic              ram_we;
  logic [SHIFT+8:0]  ram_addr;
  logic [7:0]        ram_data;
  logic              cpu_reset;
  logic              loading;
  logic              load_done;
  logic              load_error;

  rom_load_sequencer #(
    .BASE_SECTOR(BASE), .SECTOR_SHIFT(SHIFT),
    .TIMEOUT_CYCLES(TMO), .RELEASE_CYCLES(REL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .do_load_rom(do_load_rom),
    .selected_rom(selected_rom), .sd_initialized(sd_initialized),
    .sd_rd_req(sd_rd_req), .sd_rd_sector(sd_rd_sector), .sd_rd_ack(sd_rd_ack),
    .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .cpu_reset(cpu_reset),
    .loading(loading), .load_done(load_done), .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { int c; int addr; int data; } wr_t;
  wr_t wq[$];
  wr_t e;
  int  exp_done_cyc = -1;
  logic        prev_req = 1'b0;
  logic [31:0] prev_sec = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Sector address from the slot arithmetic: slot * 2^SHIFT sectors past BASE.
  function automatic logic [31:0] exp_sector(input int slot, input int s);
    return BASE + 32'(slot) * 32'(NSEC) + 32'(s);
  endfunction

  // Per-cycle compare: RAM writes exactly as predicted, load_done only when predicted,
  // sector address stable while a request is held.
  always @(negedge clk) begin
    if (reset_n && cyc > 3) begin
      if (wq.size() > 0 && wq[0].c <= cyc) begin
        e = wq.pop_front();
        chk("ram_we", ram_we, 1);
        chk("wr_cycle", cyc, e.c);
        chk("ram_addr", ram_addr, e.addr);
        chk("ram_data", ram_data, e.data);
      end else begin
        chk("ram_we_quiet", ram_we, 0);
      end
      chk("load_done", load_done, cyc == exp_done_cyc);
      if (sd_rd_req && prev_req) chk("sector_stable", sd_rd_sector, prev_sec);
      prev_req = sd_rd_req;
      prev_sec = sd_rd_sector;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int slot);
    do_load_rom  = 1'b1;
    selected_rom = 16'(slot);
    tick();
    do_load_rom  = 1'b0;
    $display("request slot %0d at cycle %0d", slot, cyc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!sd_rd_req && n < 20000) begin
      tick();
      n++;
    end
    ok = sd_rd_req;
    if (!ok) chk("sd_rd_req_seen", sd_rd_req, 1);
  endtask

  task automatic stray_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      sd_byte_valid = 1'b1;
      sd_byte       = 8'($urandom);
      tick();
      sd_byte_valid = 1'b0;
      tick();
    end
  endtask

  // Emulates the SD reader for one slot; stop_after<0 means deliver the whole slot.
  task automatic serve_load(input int slot, input int ack_dly, input int gap_max,
                            input int stop_after, input int lit0,
                            input int p1_at, input int p1_slot,
                            input int p2_at, input int p2_slot, output int last_c);
    int cnt = 0;
    bit ok;
    wr_t w;
    last_c = cyc;
    for (int s = 0; s < NSEC; s++) begin
      wait_req(ok);
      if (!ok) return;
      chk("sd_rd_sector", sd_rd_sector, exp_sector(slot, s));
      if (lit0 >= 0) chk("sector_literal", sd_rd_sector, 32'(lit0 + s));
      chk("cpu_reset_during_load", cpu_reset, 1);
      chk("loading_during_load", loading, 1);
      $display("read sector %0d (slot %0d) at cycle %0d", sd_rd_sector, slot, cyc);
      repeat (ack_dly) tick();
      chk("req_held", sd_rd_req, 1);
      sd_rd_ack = 1'b1;
      tick();
      sd_rd_ack = 1'b0;
      chk("req_dropped", sd_rd_req, 0);
      for (int b = 0; b < 512; b++) begin
        if (cnt == stop_after) return;
        repeat ($urandom_range(gap_max, 0)) tick();
        if (cnt == p1_at) begin do_load_rom = 1'b1; selected_rom = 16'(p1_slot); end
        if (cnt == p2_at) begin do_load_rom = 1'b1; selected_rom = 16'(p2_slot); end
        sd_byte_valid = 1'b1;
        sd_byte       = 8'($urandom);
        w.c    = cyc + 1;
        w.addr = s * 512 + b;
        w.data = int'(sd_byte);
        wq.push_back(w);
        last_c = cyc + 1;
        tick();
        sd_byte_valid = 1'b0;
        do_load_rom   = 1'b0;
        cnt++;
      end
    end
  endtask

  task automatic check_done(input int last_c, input bit restart);
    exp_done_cyc = last_c + int'(REL);
    wait_until(last_c + int'(REL) - 1);
    chk("cpu_reset_before_release", cpu_reset, 1);
    chk("loading_before_release", loading, 1);
    tick();
    chk("cpu_reset_released", cpu_reset, 0);
    chk("loading_cleared", loading, 0);
    chk("load_done_pulse", load_done, 1);
    chk("load_error_clear", load_error, 0);
    $display("load done at cycle %0d (last write %0d)", cyc, last_c);
    tick();
    chk("cpu_reset_after_done", cpu_reset, restart);
    chk("loading_after_done", loading, restart);
  endtask

  task automatic check_reset_values();
    chk("rst_sd_rd_req", sd_rd_req, 0);
    chk("rst_sd_rd_sector", sd_rd_sector, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_loading", loading, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    int r;
    reset_n = 1'b0; do_load_rom = 1'b0; selected_rom = '0; sd_initialized = 1'b1;
    sd_rd_ack = 1'b0; sd_byte_valid = 1'b0; sd_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset_n = 1'b1;
    tick(); tick();

    // Bytes with no load running must never reach RAM.
    stray_bytes(5);
    chk("idle_no_req", sd_rd_req, 0);
    chk("idle_cpu_reset", cpu_reset, 1);

    // Basic load of slot 3: sectors 106 and 107.
    pulse(3);
    serve_load(3, 2, 0, -1, 106, -1, 0, -1, 0, L);
    check_done(L, 1'b0);

    // Back-pressure: 50-cycle ack delay and random byte gaps.
    r = $urandom_range(65535, 0);
    pulse(r);
    serve_load(r, 50, 10, -1, -1, -1, 0, -1, 0, L);
    check_done(L, 1'b0);

    // SD not ready: the load waits indefinitely, ignoring bytes.
    sd_initialized = 1'b0;
    r = $urandom_range(65535, 0);
    pulse(r);
    for (int i = 0; i < 10000; i++) begin
      sd_byte_valid = (i % 1000 == 500);
      tick();
      sd_byte_valid = 1'b0;
      chk("sd_wait_no_req", sd_rd_req, 0);
    end
    chk("sd_wait_loading", loading, 1);
    chk("sd_wait_cpu_reset", cpu_reset, 1);
    sd_initialized = 1'b1;
    serve_load(r, 5, 10, -1, -1, -1, 0, -1, 0, L);
    check_done(L, 1'b0);

    // Timeout after 200 bytes, then recovery with slot 0.
    pulse(7);
    serve_load(7, 3, 10, 200, -1, -1, 0, -1, 0, L);
    wait_until(L + 99);
    chk("timeout_not_yet", load_error, 0);
    tick();
    chk("timeout_error", load_error, 1);
    chk("timeout_cpu_reset", cpu_reset, 1);
    chk("timeout_loading", loading, 0);
    chk("timeout_no_req", sd_rd_req, 0);
    $display("timeout error at cycle %0d (last write %0d)", cyc, L);
    pulse(0);
    tick();
    chk("retry_error_cleared", load_error, 0);
    chk("retry_loading", loading, 1);
    serve_load(0, 2, 10, -1, 100, -1, 0, -1, 0, L);
    check_done(L, 1'b0);

    // Queued requests: slot 2 then 5 during slot 1, only slot 5 follows.
    pulse(1);
    serve_load(1, 4, 5, -1, 102, 100, 2, 600, 5, L);
    check_done(L, 1'b1);
    serve_load(5, 4, 5, -1, 110, -1, 0, -1, 0, L);
    check_done(L, 1'b0);
    repeat (50) tick();
    chk("no_extra_load", sd_rd_req, 0);
    chk("no_extra_loading", loading, 0);

    // Asynchronous reset in the middle of DATA, right as a write appears.
    pulse(9);
    serve_load(9, 2, 5, 300, -1, -1, 0, -1, 0, L);
    sd_byte_valid = 1'b1;
    sd_byte       = 8'($urandom);
    tick();
    sd_byte_valid = 1'b0;
    reset_n = 1'b0;
    wq.delete();
    #1;
    check_reset_values();
    $display("async reset applied at cycle %0d", cyc);
    stray_bytes(3);
    reset_n = 1'b1;
    stray_bytes(10);
    chk("post_reset_no_req", sd_rd_req, 0);
    chk("post_reset_cpu_reset", cpu_reset, 1);
    chk("post_reset_loading", loading, 0);
    chk("no_pending_writes", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
